// File: rtl/bin2ascii_pkg.sv
// bin2ascii_pkg: shared state encoding, ASCII constants and nibble-to-ASCII mapping.
// CR/LF states exist only when BIN2ASCII_CRLF_EN is defined.
package bin2ascii_pkg;

`ifdef BIN2ASCII_CRLF_EN
    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} state_t;
`else
    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT} state_t;
`endif

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_X    = 8'h78;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_A_LO = 8'h61;
    localparam logic [7:0] CH_A_UP = 8'h41;

    function automatic logic [7:0] nibble2ascii(input logic [3:0] nibble, input logic upper);
        return (nibble < 4'd10) ? CH_0 + {4'h0, nibble}
                                : (upper ? CH_A_UP : CH_A_LO) + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2ascii_lzd.sv
// bin2ascii_lzd: index of the highest non-zero nibble of a word, 0 for an all-zero word.
module bin2ascii_lzd #(
    parameter int DATA_W = 16,
    parameter int DW     = 2
) (
    input  logic [DATA_W-1:0] bin_i,
    output logic [DW-1:0]     dig_o
);

    localparam int NDIG = DATA_W / 4;

    always_comb begin
        dig_o = '0;
        for (int i = 1; i < NDIG; i++)
            if (bin_i[4*i +: 4] != 4'h0) dig_o = DW'(i);
    end

endmodule

// File: rtl/bin2ascii_stream.sv
// bin2ascii_stream: streams a binary word as hex ASCII, one character per handshake.
// Defining BIN2ASCII_CRLF_EN appends CR LF to every word.
module bin2ascii_stream
    import bin2ascii_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit UPPER  = 1'b0,
    parameter bit PREFIX = 1'b0
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_BIN_VALID,
    output logic              O_BIN_READY,
    input  logic [DATA_W-1:0] I_BIN,
    input  logic              I_ZSUP,
    output logic              O_CHAR_VALID,
    input  logic              I_CHAR_READY,
    output logic [7:0]        O_CHAR,
    output logic              O_CHAR_LAST,
    output logic              O_BUSY
);

    localparam int NDIG = DATA_W / 4;
    localparam int DW   = NDIG > 1 ? $clog2(NDIG) : 1;
`ifdef BIN2ASCII_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [DW-1:0]     dig_q;
    logic [DW-1:0]     lzd_dig;
    logic [DW-1:0]     start_d;
    logic [7:0]        char_q;
    logic              valid_q;
    logic              last_q;

    bin2ascii_lzd #(.DATA_W(DATA_W), .DW(DW)) u_lzd (
        .bin_i (I_BIN),
        .dig_o (lzd_dig)
    );

    assign start_d = I_ZSUP ? lzd_dig : DW'(NDIG - 1);

    function automatic logic [7:0] char_at(input logic [DATA_W-1:0] w, input logic [DW-1:0] d);
        return nibble2ascii(4'(w >> {d, 2'b00}), UPPER);
    endfunction

    // Every state but IDLE holds a valid character, so a transfer is just I_CHAR_READY there.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= IDLE;
            word_q  <= '0;
            dig_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (I_BIN_VALID) begin
                    word_q  <= I_BIN;
                    dig_q   <= start_d;
                    valid_q <= 1'b1;
                    state_q <= PREFIX ? PFX0 : DIGIT;
                    char_q  <= PREFIX ? CH_0 : char_at(I_BIN, start_d);
                    last_q  <= !PREFIX && !CRLF && start_d == '0;
                end
                PFX0: if (I_CHAR_READY) begin
                    state_q <= PFX1;
                    char_q  <= CH_X;
                end
                PFX1: if (I_CHAR_READY) begin
                    state_q <= DIGIT;
                    char_q  <= char_at(word_q, dig_q);
                    last_q  <= !CRLF && dig_q == '0;
                end
                DIGIT: if (I_CHAR_READY) begin
                    if (dig_q == '0) begin
`ifdef BIN2ASCII_CRLF_EN
                        state_q <= CR;
                        char_q  <= CH_CR;
`else
                        state_q <= IDLE;
                        valid_q <= 1'b0;
`endif
                        last_q  <= 1'b0;
                    end else begin
                        dig_q  <= dig_q - 1'b1;
                        char_q <= char_at(word_q, dig_q - 1'b1);
                        last_q <= !CRLF && dig_q == DW'(1);
                    end
                end
`ifdef BIN2ASCII_CRLF_EN
                CR: if (I_CHAR_READY) begin
                    state_q <= LF;
                    char_q  <= CH_LF;
                    last_q  <= 1'b1;
                end
                LF: if (I_CHAR_READY) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_BIN_READY  = state_q == IDLE && !I_RST;
    assign O_BUSY       = state_q != IDLE;
    assign O_CHAR_VALID = valid_q;
    assign O_CHAR       = char_q;
    assign O_CHAR_LAST  = last_q;

endmodule

// File: tb/tb_bin2ascii_stream.sv
// tb_bin2ascii_stream: directed checks of two configurations (plain, and upper-case with prefix).
// Expected CR/LF tails are added when BIN2ASCII_CRLF_EN is defined.
module tb_bin2ascii_stream;

`ifdef BIN2ASCII_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bin = '0;
    logic        zsup = 1'b0;
    logic        cready = 1'b0;
    logic        vld0 = 1'b0;
    logic        vld1 = 1'b0;
    logic        sel = 1'b0;
    logic        brdy0, cv0, cl0, busy0, brdy1, cv1, cl1, busy1;
    logic [7:0]  ch0, ch1;
    logic        ob, ov, ol, obusy;
    logic [7:0]  och;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    bin2ascii_stream #(.DATA_W(16), .UPPER(1'b0), .PREFIX(1'b0)) u0 (
        .I_CLK(clk), .I_RST(rst), .I_BIN_VALID(vld0), .O_BIN_READY(brdy0), .I_BIN(bin),
        .I_ZSUP(zsup), .O_CHAR_VALID(cv0), .I_CHAR_READY(cready), .O_CHAR(ch0),
        .O_CHAR_LAST(cl0), .O_BUSY(busy0)
    );

    bin2ascii_stream #(.DATA_W(16), .UPPER(1'b1), .PREFIX(1'b1)) u1 (
        .I_CLK(clk), .I_RST(rst), .I_BIN_VALID(vld1), .O_BIN_READY(brdy1), .I_BIN(bin),
        .I_ZSUP(zsup), .O_CHAR_VALID(cv1), .I_CHAR_READY(cready), .O_CHAR(ch1),
        .O_CHAR_LAST(cl1), .O_BUSY(busy1)
    );

    assign ob    = sel ? brdy1 : brdy0;
    assign ov    = sel ? cv1 : cv0;
    assign ol    = sel ? cl1 : cl0;
    assign och   = sel ? ch1 : ch0;
    assign obusy = sel ? busy1 : busy0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp holds n characters, first character in the most significant used byte
    task automatic send(input logic s, input logic [15:0] w, input logic z,
                        input logic [63:0] exp, input int n, input string tag);
        logic [63:0] e;
        int          m;
        e = CRLF ? {exp[47:0], 16'h0D0A} : exp;
        m = CRLF ? n + 2 : n;
        sel = s;
        bin = w;
        zsup = z;
        cready = 1'b1;
        chk({tag, "_ready"}, 64'(ob), 64'd1);
        if (s) vld1 = 1'b1; else vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        vld1 = 1'b0;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_v%0d", tag, i), 64'(ov), 64'd1);
            chk($sformatf("%s_c%0d", tag, i), 64'(och), 64'(e[8*(m-1-i) +: 8]));
            chk($sformatf("%s_l%0d", tag, i), 64'(ol), 64'(i == m - 1));
            tick();
        end
        chk({tag, "_vdone"}, 64'(ov), 64'd0);
        chk({tag, "_busy"}, 64'(obusy), 64'd0);
        chk({tag, "_rdy"}, 64'(ob), 64'd1);
    endtask

    initial begin
        logic [7:0] ex[16];
        logic [7:0] rx[16];
        logic [7:0] hold;
        logic       hold_l;
        logic       prev_stall;
        int         ne;
        int         got;
        int         acc;

        tick();
        tick();
        chk("rst_valid", 64'(cv0), 64'd0);
        chk("rst_char", 64'(ch0), 64'h00);
        chk("rst_last", 64'(cl0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_ready", 64'(brdy0), 64'd0);
        chk("rst_ready1", 64'(brdy1), 64'd0);
        rst = 1'b0;
        #1;

        send(1'b0, 16'h3A7F, 1'b0, 64'h33613766, 4, "plain");
        send(1'b0, 16'h0042, 1'b1, 64'h3432, 2, "zsup42");
        send(1'b0, 16'h0000, 1'b1, 64'h30, 1, "zsup0");
        send(1'b0, 16'h0001, 1'b0, 64'h30303031, 4, "one");
        send(1'b1, 16'hBEEF, 1'b0, 64'h307842454546, 6, "pfx");
        send(1'b1, 16'h0000, 1'b1, 64'h307830, 3, "pfxz");

        // Backpressure with valid held high across two words
        ne = 0;
        for (int i = 0; i < 8; i++) begin
            ex[ne] = 8'h31 + 8'(i);
            ne++;
            if (CRLF && (i == 3 || i == 7)) begin
                ex[ne] = 8'h0D;
                ex[ne+1] = 8'h0A;
                ne += 2;
            end
        end
        sel = 1'b0;
        zsup = 1'b0;
        bin = 16'h1234;
        vld0 = 1'b1;
        got = 0;
        acc = 0;
        prev_stall = 1'b0;
        hold = 8'h00;
        hold_l = 1'b0;
        for (int c = 0; c < 120 && got < ne; c++) begin
            cready = (c % 2 == 0);
            if (prev_stall) begin
                chk($sformatf("stall_v%0d", c), 64'(ov), 64'd1);
                chk($sformatf("stall_c%0d", c), 64'(och), 64'(hold));
                chk($sformatf("stall_l%0d", c), 64'(ol), 64'(hold_l));
            end
            if (ov && cready) begin
                rx[got] = och;
                got++;
            end
            prev_stall = ov && !cready;
            hold = och;
            hold_l = ol;
            if (vld0 && ob) acc++;
            tick();
            if (acc == 1) bin = 16'h5678;
            if (acc == 2) vld0 = 1'b0;
        end
        vld0 = 1'b0;
        chk("stall_count", 64'(got), 64'(ne));
        chk("stall_accepts", 64'(acc), 64'd2);
        for (int i = 0; i < ne && i < got; i++)
            chk($sformatf("stall_rx%0d", i), 64'(rx[i]), 64'(ex[i]));
        cready = 1'b1;
        tick();
        tick();

        // Reset in the middle of a word, together with a pending accept
        sel = 1'b0;
        bin = 16'hABCD;
        vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        chk("mid_c0", 64'(och), 64'h61);
        tick();
        chk("mid_c1", 64'(och), 64'h62);
        tick();
        chk("mid_c2", 64'(och), 64'h63);
        rst = 1'b1;
        vld0 = 1'b1;
        #1;
        chk("mid_rdy_rst", 64'(ob), 64'd0);
        tick();
        rst = 1'b0;
        vld0 = 1'b0;
        chk("mid_valid", 64'(ov), 64'd0);
        chk("mid_busy", 64'(obusy), 64'd0);
        chk("mid_last", 64'(ol), 64'd0);
        tick();
        chk("mid_noresume", 64'(ov), 64'd0);
        send(1'b0, 16'h0F0F, 1'b0, 64'h30663066, 4, "after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
